adder32_rr_arbiter: RTL and testbench

//  Shares one adder32 instance (32-bit a+b+cin) among NREQ requesters using round-robin grant.
//  Per-requester valid/ready request handshake; a single registered response with valid/ready backpressure.
//  One add is in flight at a time. Sits between the multiplier-side producers and the shared final adder.

---
 rtl/adder32_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_adder32_rr_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/adder32_rr_arbiter.sv
// Round-robin arbiter that shares one 32-bit adder (a+b+cin) among NREQ requesters.
// Optional ADDER_ARB_OVF_EN adds a registered two's-complement overflow flag (rsp_ovf).
module adder32
  (input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

module adder32_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*32-1:0]  req_a,
   input  logic [NREQ*32-1:0]  req_b,
   input  logic [NREQ-1:0]     req_cin,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [31:0]         rsp_sum,
   output logic                rsp_carry
`ifdef ADDER_ARB_OVF_EN
  ,output logic                rsp_ovf
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef struct packed {
      logic [31:0]    a;
      logic [31:0]    b;
      logic           cin;
      logic [IDW-1:0] id;
   } op_t;

   state_t                 state, state_nxt;
   op_t                    op;
   logic [IDW-1:0]         rr_ptr;
   logic [IDW-1:0]         idx;
   logic [IDW-1:0]         gnt_id;
   logic                   gnt_vld;
   logic                   take;
   logic [NREQ-1:0][31:0]  a_arr, b_arr;
   logic [31:0]            sum;
   logic                   cout;

   assign a_arr = req_a;
   assign b_arr = req_b;

   adder32 u_add (.a(op.a), .b(op.b), .cin(op.cin), .sum(sum), .cout(cout));

   // first valid requester scanning from rr_ptr upward, wrapping at NREQ
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx     = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = IDW'((int'(rr_ptr) + i) % NREQ);
         if (!gnt_vld && req_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = idx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      take      = 1'b0;
      case (state)
         IDLE: if (gnt_vld && !rst) begin
            req_ready[gnt_id] = 1'b1;
            take              = 1'b1;
            state_nxt         = EXEC;
         end
         EXEC: state_nxt = RESP;
         RESP: if (rsp_valid && rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         op        <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_carry <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
         rsp_ovf   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (take) begin
            op     <= '{a: a_arr[gnt_id], b: b_arr[gnt_id], cin: req_cin[gnt_id], id: gnt_id};
            rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
         end
         if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= op.id;
            rsp_sum   <= sum;
            rsp_carry <= cout;
`ifdef ADDER_ARB_OVF_EN
            rsp_ovf   <= (op.a[31] == op.b[31]) && (sum[31] != op.a[31]);
`endif
         end
         if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adder32_rr_arbiter.sv
// Directed bench for adder32_rr_arbiter: reset, grant order, backpressure, carry, reset mid-op.
module tb_adder32_rr_arbiter;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        req_valid;
   logic [3:0]        req_ready;
   logic [3:0][31:0]  ra, rb;
   logic [3:0]        req_cin;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_id;
   logic [31:0]       rsp_sum;
   logic              rsp_carry;
`ifdef ADDER_ARB_OVF_EN
   logic              rsp_ovf;
`endif

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_sum [4];
   int          exp_order [6];

   adder32_rr_arbiter #(.NREQ(4), .IDW(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(ra), .req_b(rb), .req_cin(req_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry)
`ifdef ADDER_ARB_OVF_EN
     ,.rsp_ovf(rsp_ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      exp_sum   = '{32'h1111_1111, 32'h2222_2224, 32'h3333_3335, 32'h4444_4448};
      exp_order = '{0, 1, 2, 3, 0, 1};
      rst = 1'b1; req_valid = '0; ra = '0; rb = '0; req_cin = '0; rsp_ready = 1'b0;
      tick(); tick();
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_sum",   rsp_sum, 0);
      chk("rst_rsp_id",    32'(rsp_id), 0);
      chk("rst_rsp_carry", 32'(rsp_carry), 0);
      req_valid = 4'b1111; #1;
      chk("rst_req_ready", 32'(req_ready), 0);
      req_valid = '0;
      rst = 1'b0; tick();

      // single request from requester 2
      ra[2] = 32'h5; rb[2] = 32'h3; req_cin[2] = 1'b1; rsp_ready = 1'b1;
      req_valid = 4'b0100; #1;
      chk("t1_grant", 32'(req_ready), 32'h4);
      tick(); req_valid = '0; #1;
      chk("t1_exec_ready", 32'(req_ready), 0);
      chk("t1_exec_valid", 32'(rsp_valid), 0);
      tick();
      chk("t1_rsp_valid", 32'(rsp_valid), 1);
      chk("t1_rsp_id",    32'(rsp_id), 2);
      chk("t1_rsp_sum",   rsp_sum, 32'h9);
      chk("t1_rsp_carry", 32'(rsp_carry), 0);
      tick();
      chk("t1_done_valid", 32'(rsp_valid), 0);
      chk("t1_retain_sum", rsp_sum, 32'h9);

      // reset so the scan starts at 0, then all requesters valid
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ra[i] = 32'h1111_1111 * (i + 1);
         rb[i] = 32'(i);
         req_cin[i] = i[0];
      end
      req_valid = 4'b1111; #1;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1) << exp_order[k]);
         tick();
         chk($sformatf("rr_exec_ready%0d", k), 32'(req_ready), 0);
         tick();
         chk($sformatf("rr_valid%0d", k), 32'(rsp_valid), 1);
         chk($sformatf("rr_id%0d", k), 32'(rsp_id), 32'(exp_order[k]));
         chk($sformatf("rr_sum%0d", k), rsp_sum, exp_sum[exp_order[k]]);
         tick();
      end

      // backpressure: grant 2 held for 5 cycles
      rsp_ready = 1'b0; #1;
      chk("bp_grant", 32'(req_ready), 32'h4);
      tick(); tick();
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp_valid%0d", k), 32'(rsp_valid), 1);
         chk($sformatf("bp_id%0d", k), 32'(rsp_id), 2);
         chk($sformatf("bp_sum%0d", k), rsp_sum, 32'h3333_3335);
         chk($sformatf("bp_ready%0d", k), 32'(req_ready), 0);
         tick();
      end
      rsp_ready = 1'b1; #1;
      chk("bp_last_valid", 32'(rsp_valid), 1);
      chk("bp_last_ready", 32'(req_ready), 0);
      tick();
      chk("bp_accepted", 32'(rsp_valid), 0);
      chk("bp_next_grant", 32'(req_ready), 32'h8);
      tick(); req_valid = '0; tick();
      chk("bp_next_id",  32'(rsp_id), 3);
      chk("bp_next_sum", rsp_sum, 32'h4444_4448);
      tick();

      // carry out of bit 31 (rr_ptr back at 0, requester 1 is first valid)
      ra[1] = 32'hFFFF_FFFF; rb[1] = 32'h0; req_cin[1] = 1'b1;
      req_valid = 4'b0010; #1;
      chk("cy_grant", 32'(req_ready), 32'h2);
      tick(); req_valid = '0; tick();
      chk("cy_sum",   rsp_sum, 32'h0);
      chk("cy_carry", 32'(rsp_carry), 1);
      chk("cy_id",    32'(rsp_id), 1);
      tick();
`ifdef ADDER_ARB_OVF_EN
      ra[3] = 32'h7FFF_FFFF; rb[3] = 32'h1; req_cin[3] = 1'b0;
      req_valid = 4'b1000; #1;
      tick(); req_valid = '0; tick();
      chk("ovf_sum",  rsp_sum, 32'h8000_0000);
      chk("ovf_flag", 32'(rsp_ovf), 1);
      tick();
`endif

      // reset during EXEC abandons the op
      ra[0] = 32'h1; rb[0] = 32'h1; req_cin[0] = 1'b0;
      req_valid = 4'b0001; #1;
      chk("rx_grant", 32'(req_ready), 32'h1);
      tick(); req_valid = '0;
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rx_valid",  32'(rsp_valid), 0);
      chk("rx_sum",    rsp_sum, 0);
      chk("rx_carry",  32'(rsp_carry), 0);
      chk("rx_id",     32'(rsp_id), 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("rx_quiet%0d", k), 32'(rsp_valid), 0);
      end
      ra[3] = 32'hDEAD_0000; rb[3] = 32'h0000_BEEF; req_cin[3] = 1'b0;
      req_valid = 4'b1000; #1;
      chk("rx_grant3", 32'(req_ready), 32'h8);
      tick(); req_valid = '0; tick();
      chk("rx_valid3", 32'(rsp_valid), 1);
      chk("rx_id3",    32'(rsp_id), 3);
      chk("rx_sum3",   rsp_sum, 32'hDEAD_BEEF);
      tick();
      chk("rx_done3",  32'(rsp_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
